// File: rtl/online_to_conv_r4.sv
// Radix-4 on-the-fly converter: MSD-first signed digits {-3..3} in, two's complement out.
// Q/QM register pair, so each digit is absorbed by a 2-bit shift-and-append with no wide adder.
module online_to_conv_r4 #(
  parameter int N  = 8,
  parameter int ZW = 2*N+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          di_valid,
  input  logic          di_first,
  input  logic [2:0]    di,
  output logic          busy,
  output logic [ZW-1:0] zo,
  output logic          zo_valid,
  output logic          err
);
  localparam int CW = $clog2(N+1);

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ZW-1:0]   q_q, q_d, qm_q, qm_d, zo_q, zo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            zo_valid_q, zo_valid_d, err_q, err_d, busy_q, busy_d;

  logic [ZW-1:0]   q_base_s, qm_base_s, q_new_s, qm_new_s;
  logic            d_pos_s, d_neg_s, d_zero_s, d_illegal_s;
  logic [1:0]      dm1_s;

  // Digit decode and Q/QM append; a new MSD starts from Q=0, QM=-1
  always_comb begin
    d_neg_s     = di[2];
    d_zero_s    = (di == 3'b000);
    d_pos_s     = !di[2] && !d_zero_s;
    d_illegal_s = (di == 3'b100);
    dm1_s       = di[1:0] - 2'd1;
    if (di_first) begin
      q_base_s  = {ZW{1'b0}};
      qm_base_s = {ZW{1'b1}};
    end else begin
      q_base_s  = q_q;
      qm_base_s = qm_q;
    end
    // Low bits: Q gets d mod 4, QM gets (d-1) mod 4 in every case
    q_new_s  = d_neg_s ? {qm_base_s[ZW-3:0], di[1:0]} : {q_base_s[ZW-3:0], di[1:0]};
    qm_new_s = d_pos_s ? {q_base_s[ZW-3:0], dm1_s}    : {qm_base_s[ZW-3:0], dm1_s};
  end

  // Next-state logic: load, accumulate, complete, abort-and-restart
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    qm_d       = qm_q;
    cnt_d      = cnt_q;
    zo_d       = zo_q;
    zo_valid_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (di_valid && di_first) begin
          state_d = CONV;
          q_d     = q_new_s;
          qm_d    = qm_new_s;
          cnt_d   = CW'(1);
          err_d   = d_illegal_s;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (di_valid) begin
          if (di_first) begin
            q_d   = q_new_s;
            qm_d  = qm_new_s;
            cnt_d = CW'(1);
            err_d = d_illegal_s;
          end else if (cnt_q == CW'(N-1)) begin
            state_d    = IDLE;
            q_d        = {ZW{1'b0}};
            qm_d       = {ZW{1'b1}};
            cnt_d      = {CW{1'b0}};
            zo_d       = q_new_s;
            zo_valid_d = 1'b1;
            err_d      = err_q | d_illegal_s;
          end else begin
            q_d   = q_new_s;
            qm_d  = qm_new_s;
            cnt_d = cnt_q + CW'(1);
            err_d = err_q | d_illegal_s;
          end
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = {ZW{1'b0}};
        qm_d    = {ZW{1'b1}};
        cnt_d   = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d == CONV);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      q_q        <= {ZW{1'b0}};
      qm_q       <= {ZW{1'b1}};
      cnt_q      <= {CW{1'b0}};
      zo_q       <= {ZW{1'b0}};
      zo_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      qm_q       <= qm_d;
      cnt_q      <= cnt_d;
      zo_q       <= zo_d;
      zo_valid_q <= zo_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign zo       = zo_q;
  assign zo_valid = zo_valid_q;
  assign err      = err_q;
endmodule

// File: tb/tb_online_to_conv_r4.sv
// Bench for online_to_conv_r4 (N=4): integer reference model checked every cycle,
// directed literal cases, then randomized digit streams.
module tb_online_to_conv_r4;
  localparam int N  = 4;
  localparam int ZW = 2*N+1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          di_valid = 1'b0;
  logic          di_first = 1'b0;
  logic [2:0]    di = 3'b000;
  logic          busy;
  logic [ZW-1:0] zo;
  logic          zo_valid;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  online_to_conv_r4 #(.N(N), .ZW(ZW)) dut (
    .clk(clk), .reset(reset), .di_valid(di_valid), .di_first(di_first), .di(di),
    .busy(busy), .zo(zo), .zo_valid(zo_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: value accumulated as plain integer acc = 4*acc + d
  bit m_active = 1'b0;
  int m_cnt = 0;
  int m_acc = 0;
  bit m_err = 1'b0;
  int m_zo = 0;
  bit m_zo_known = 1'b1;
  bit m_zo_valid = 1'b0;

  always @(posedge clk or negedge reset) begin
    int d;
    if (!reset) begin
      m_active = 1'b0; m_cnt = 0; m_acc = 0; m_err = 1'b0;
      m_zo = 0; m_zo_known = 1'b1; m_zo_valid = 1'b0;
    end else begin
      m_zo_valid = 1'b0;
      d = int'($signed(di));
      if (di_valid) begin
        if (di_first) begin
          m_active = 1'b1; m_cnt = 1; m_acc = d; m_err = (di == 3'b100);
        end else if (m_active) begin
          m_acc = m_acc * 4 + d;
          m_cnt = m_cnt + 1;
          if (di == 3'b100) m_err = 1'b1;
          if (m_cnt == N) begin
            m_active = 1'b0; m_cnt = 0; m_zo_valid = 1'b1;
            m_zo = m_acc; m_zo_known = !m_err;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", int'(busy), int'(m_active));
      chk("zo_valid", int'(zo_valid), int'(m_zo_valid));
      chk("err", int'(err), int'(m_err));
      if (m_zo_known) chk("zo", int'($signed(zo)), m_zo);
    end
  end

  task automatic drive(input bit v, input bit f, input int d);
    di_valid = v; di_first = f; di = d[2:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  task automatic send_op(input int d0, input int d1, input int d2, input int d3,
                         input int g1, input int g2, input int g3,
                         input int exp, input bit exp_err, input string name);
    drive(1'b1, 1'b1, d0); idle(g1);
    drive(1'b1, 1'b0, d1); idle(g2);
    drive(1'b1, 1'b0, d2); idle(g3);
    drive(1'b1, 1'b0, d3);
    chk({name, ".zo_valid"}, int'(zo_valid), 1);
    chk({name, ".err"}, int'(err), int'(exp_err));
    if (!exp_err) chk({name, ".zo"}, int'($signed(zo)), exp);
  endtask

  initial begin
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.zo", int'(zo), 0);
    chk("rst.zo_valid", int'(zo_valid), 0);
    chk("rst.err", int'(err), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(2);

    send_op(3, 3, 3, 3, 0, 0, 0, 255, 1'b0, "t1");
    idle(1);
    chk("t1.pulse", int'(zo_valid), 0);
    send_op(-3, -3, -3, -3, 0, 0, 0, -255, 1'b0, "t2a");
    chk("t2a.bits", int'(zo), 9'h101);
    idle(1);
    send_op(1, -2, 0, 3, 0, 0, 0, 35, 1'b0, "t2b");
    idle(1);
    send_op(0, -1, 2, -3, 0, 0, 0, -11, 1'b0, "t2c");
    idle(1);
    send_op(1, -2, 0, 3, 0, 2, 5, 35, 1'b0, "t3");
    idle(2);

    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 2);
    send_op(2, 0, 0, -1, 0, 0, 0, 127, 1'b0, "t4a");
    send_op(0, 0, 0, 1, 0, 0, 0, 1, 1'b0, "t4b");
    idle(1);

    send_op(1, -4, 0, 0, 0, 0, 0, 0, 1'b1, "t5a");
    idle(1);
    send_op(1, 0, 0, 0, 0, 0, 0, 64, 1'b0, "t5b");
    idle(1);

    drive(1'b1, 1'b1, 2);
    drive(1'b1, 1'b0, 1);
    di_valid = 1'b0; di_first = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("t6.busy", int'(busy), 0);
    chk("t6.zo", int'(zo), 0);
    chk("t6.zo_valid", int'(zo_valid), 0);
    chk("t6.err", int'(err), 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b0, 3);
    chk("t6.ignored", int'(busy), 0);
    send_op(2, -1, 3, 0, 0, 0, 0, 124, 1'b0, "t6");
    idle(1);

    for (int c = 0; c < 3000; c++) begin
      bit v, f;
      int d;
      v = ($urandom_range(0, 3) != 0);
      f = m_active ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) d = -4;
      else d = int'($urandom_range(0, 6)) - 3;
      drive(v, f, d);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
